// File: rtl/mul_acc_if.sv
// Product-in / sum-out handshake bundle for mul_product_accumulator.
// Both ports are valid/ready: a transfer happens on a rising edge where valid && ready.
interface mul_acc_if #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40
);
  logic [PROD_W-1:0] prod_in;
  logic              prod_valid;
  logic              prod_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid;
  logic              acc_ready;
  logic              overflow;

  // The accumulator is the slave on both channels (it sinks products and offers sums).
  modport slave (
    input  prod_in, prod_valid, acc_ready,
    output prod_ready, acc_out, acc_valid, overflow
  );

  modport master (
    output prod_in, prod_valid, acc_ready,
    input  prod_ready, acc_out, acc_valid, overflow
  );
endinterface

// File: rtl/mul_product_accumulator.sv
// Sums blocks of block_len multiplier products and offers each sum on a valid/ready port.
// Define MUL_ACC_SAT_EN to saturate the sum on carry-out instead of wrapping modulo 2^ACC_W.
module mul_product_accumulator #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] block_len,
  output logic             busy,
  output logic [1:0]       state_o,
  mul_acc_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [ACC_W:0]   sum_w;
  logic [CNT_W:0]   cnt_inc;

  // A length of 0 stands for 2^CNT_W, hence the extra counter bit.
  function automatic logic [CNT_W:0] eff_len(input logic [CNT_W-1:0] l);
    return (l == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, l};
  endfunction

  assign bus.prod_ready = (state_q != HOLD) && !clear;
  assign accept         = bus.prod_valid && bus.prod_ready;
  assign sum_w          = {1'b0, acc_q} + (ACC_W + 1)'(bus.prod_in);
  assign cnt_inc        = cnt_q + (CNT_W + 1)'(1);

  assign bus.acc_out    = acc_q;
  assign bus.acc_valid  = (state_q == HOLD);
  assign bus.overflow   = ovf_q;
  assign busy           = (state_q != IDLE);
  assign state_o        = state_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = ACC_W'(bus.prod_in);
            cnt_d   = (CNT_W + 1)'(1);
            len_d   = block_len;
            ovf_d   = 1'b0;
            state_d = (eff_len(block_len) == (CNT_W + 1)'(1)) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
`ifdef MUL_ACC_SAT_EN
            acc_d = sum_w[ACC_W] ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
            acc_d = sum_w[ACC_W-1:0];
`endif
            cnt_d = cnt_inc;
            ovf_d = ovf_q | sum_w[ACC_W];
            if (cnt_inc == eff_len(len_q)) state_d = HOLD;
          end
        end
        HOLD: begin
          if (bus.acc_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mul_product_accumulator.sv
// Directed bench: a 40-bit accumulator for the main behaviour and a 33-bit one for carry-out.
module tb_mul_product_accumulator;

  logic       clk;
  logic       rst_n;
  logic       clear0, clear1;
  logic [7:0] block_len0, block_len1;
  logic       busy0, busy1;
  logic [1:0] state0, state1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [40:0] exp_q0[$];
  logic [33:0] exp_q1[$];

  mul_acc_if #(.PROD_W(32), .ACC_W(40)) bus0 ();
  mul_acc_if #(.PROD_W(32), .ACC_W(33)) bus1 ();

  mul_product_accumulator #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear0), .block_len(block_len0),
    .busy(busy0), .state_o(state0), .bus(bus0)
  );

  mul_product_accumulator #(.PROD_W(32), .ACC_W(33), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .block_len(block_len1),
    .busy(busy1), .state_o(state1), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: a sum is compared when it is actually handed downstream.
  always @(negedge clk) begin
    if (rst_n && bus0.acc_valid && bus0.acc_ready) begin
      check("sb0_nonempty", 64'(exp_q0.size() != 0), 64'd1);
      if (exp_q0.size() != 0) begin
        logic [40:0] e;
        e = exp_q0.pop_front();
        check("sb0_acc_out", 64'(bus0.acc_out), 64'(e[39:0]));
        check("sb0_overflow", 64'(bus0.overflow), 64'(e[40]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus1.acc_valid && bus1.acc_ready) begin
      check("sb1_nonempty", 64'(exp_q1.size() != 0), 64'd1);
      if (exp_q1.size() != 0) begin
        logic [33:0] e;
        e = exp_q1.pop_front();
        check("sb1_acc_out", 64'(bus1.acc_out), 64'(e[32:0]));
        check("sb1_overflow", 64'(bus1.overflow), 64'(e[33]));
      end
    end
  end

  initial begin
    logic [32:0] sat_exp;
    int n;
    rst_n = 1'b0;
    clear0 = 1'b0; clear1 = 1'b0;
    block_len0 = 8'd0; block_len1 = 8'd0;
    bus0.prod_in = '0; bus0.prod_valid = 1'b0; bus0.acc_ready = 1'b0;
    bus1.prod_in = '0; bus1.prod_valid = 1'b0; bus1.acc_ready = 1'b0;

    // Reset
    repeat (3) tick();
    check("rst_prod_ready", 64'(bus0.prod_ready), 64'd1);
    check("rst_acc_valid", 64'(bus0.acc_valid), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_acc_out", 64'(bus0.acc_out), 64'd0);
    check("rst_overflow", 64'(bus0.overflow), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_prod_ready", 64'(bus0.prod_ready), 64'd1);

    // Basic 3-product block
    block_len0 = 8'd3;
    bus0.acc_ready = 1'b1;
    exp_q0.push_back({1'b0, 40'h00FFFE0011});
    bus0.prod_valid = 1'b1; bus0.prod_in = 32'd6;
    tick();
    check("b1_busy", 64'(busy0), 64'd1);
    bus0.prod_in = 32'd10;
    tick();
    check("b1_valid_early", 64'(bus0.acc_valid), 64'd0);
    bus0.prod_in = 32'hFFFE0001;
    tick();
    bus0.prod_valid = 1'b0;
    check("b1_valid", 64'(bus0.acc_valid), 64'd1);
    check("b1_acc_out", 64'(bus0.acc_out), 64'h00FFFE0011);
    check("b1_overflow", 64'(bus0.overflow), 64'd0);
    tick();
    check("b1_valid_one_cycle", 64'(bus0.acc_valid), 64'd0);
    check("b1_idle", 64'(busy0), 64'd0);

    // Backpressure with a product offered during HOLD
    block_len0 = 8'd1;
    bus0.acc_ready = 1'b0;
    exp_q0.push_back({1'b0, 40'h0012345678});
    bus0.prod_valid = 1'b1; bus0.prod_in = 32'h12345678;
    tick();
    bus0.prod_in = 32'h0000DEAD;
    for (int i = 0; i < 5; i++) begin
      bus0.prod_valid = (i == 2);
      #1;
      check("bp_valid", 64'(bus0.acc_valid), 64'd1);
      check("bp_acc_out", 64'(bus0.acc_out), 64'h0012345678);
      check("bp_prod_ready", 64'(bus0.prod_ready), 64'd0);
      tick();
    end
    bus0.prod_valid = 1'b0;
    bus0.acc_ready = 1'b1;
    tick();
    check("bp_released", 64'(bus0.acc_valid), 64'd0);
    check("bp_idle", 64'(busy0), 64'd0);

    // Length 0 means 256 products; block_len changes mid-block are ignored
    block_len0 = 8'd0;
    exp_q0.push_back({1'b0, 40'hFFFFFFFF00});
    bus0.prod_valid = 1'b1; bus0.prod_in = 32'hFFFFFFFF;
    tick();
    block_len0 = 8'd5;
    repeat (254) tick();
    check("len0_not_yet", 64'(bus0.acc_valid), 64'd0);
    check("len0_busy", 64'(busy0), 64'd1);
    tick();
    bus0.prod_valid = 1'b0;
    check("len0_valid", 64'(bus0.acc_valid), 64'd1);
    tick();

    // Clear mid-block overrides an offered product
    block_len0 = 8'd4;
    bus0.prod_valid = 1'b1; bus0.prod_in = 32'd100;
    tick();
    bus0.prod_in = 32'd200;
    tick();
    bus0.prod_in = 32'd300;
    clear0 = 1'b1;
    #1;
    check("clr_prod_ready", 64'(bus0.prod_ready), 64'd0);
    tick();
    clear0 = 1'b0;
    bus0.prod_valid = 1'b0;
    check("clr_busy", 64'(busy0), 64'd0);
    check("clr_acc_out", 64'(bus0.acc_out), 64'd0);
    check("clr_overflow", 64'(bus0.overflow), 64'd0);
    exp_q0.push_back({1'b0, 40'd10});
    bus0.prod_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus0.prod_in = 32'(i);
      tick();
    end
    bus0.prod_valid = 1'b0;
    check("clr_next_valid", 64'(bus0.acc_valid), 64'd1);
    tick();

    // Asynchronous reset between edges
    bus0.prod_valid = 1'b1; bus0.prod_in = 32'd55;
    tick();
    tick();
    bus0.prod_valid = 1'b0;
    check("ar_busy_before", 64'(busy0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", 64'(busy0), 64'd0);
    check("ar_acc_out", 64'(bus0.acc_out), 64'd0);
    check("ar_prod_ready", 64'(bus0.prod_ready), 64'd1);
    check("ar_acc_valid", 64'(bus0.acc_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Carry-out on the 33-bit instance
`ifdef MUL_ACC_SAT_EN
    sat_exp = 33'h1FFFFFFFF;
`else
    sat_exp = 33'h0FFFFFFFD;
`endif
    block_len1 = 8'd3;
    bus1.acc_ready = 1'b0;
    exp_q1.push_back({1'b1, sat_exp});
    bus1.prod_valid = 1'b1; bus1.prod_in = 32'hFFFFFFFF;
    repeat (3) tick();
    bus1.prod_valid = 1'b0;
    n = 0;
    while (!bus1.acc_valid && n < 20) begin
      tick();
      n++;
    end
    check("ovf_valid_seen", 64'(bus1.acc_valid), 64'd1);
    check("ovf_acc_out", 64'(bus1.acc_out), 64'(sat_exp));
    check("ovf_flag", 64'(bus1.overflow), 64'd1);
    bus1.acc_ready = 1'b1;
    tick();
    tick();

    check("sb0_drained", 64'(exp_q0.size()), 64'd0);
    check("sb1_drained", 64'(exp_q1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_product_accumulator.md
Name: mul_product_accumulator

Overview:
- Downstream consumer of the 16x16 unsigned multiplier. Takes a stream of 32-bit products and sums blocks of block_len consecutive products into a wide accumulator.
- Each finished sum is presented on a valid/ready output port.
- Used for dot-product and MAC-style reduction of multiplier results before writeback.

Parameters:
- PROD_W, 32, width of incoming product (2 x 16-bit operand width).
- ACC_W, 40, accumulator and result width; must be >= PROD_W.
- CNT_W, 8, width of block length and product counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; discards the partial or held sum.
- prod_in  input  PROD_W  unsigned product from the multiplier.
- prod_valid  input  1  prod_in is valid.
- prod_ready  output  1  block can accept a product this cycle.
- block_len  input  CNT_W  number of products per sum; sampled on the first product of a block; 0 means 2^CNT_W.
- acc_out  output  ACC_W  completed sum.
- acc_valid  output  1  acc_out holds a completed sum.
- acc_ready  input  1  downstream takes acc_out.
- overflow  output  1  sticky per block; set if any addition in the block carried out of ACC_W.
- busy  output  1  high in ACCUM or HOLD.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. Reset forces:
  - state=IDLE
  - acc_out=0, acc_valid=0, overflow=0, busy=0
  - counter=0, latched length=0
  - prod_ready=1
- Product handshake: a product is accepted when prod_valid && prod_ready on a rising edge. prod_in is not registered before the add.
- prod_ready = (state != HOLD) && !clear. It is combinational from state and clear only, with no dependency on prod_valid.
- States:
  - IDLE. On accept: acc <= zero-extended prod_in; cnt <= 1; len <= block_len; overflow <= 0. If the effective length is 1, go to HOLD; otherwise go to ACCUM.
  - ACCUM. On accept: {carry, acc} <= acc + zero-extended prod_in; cnt <= cnt + 1; overflow <= overflow | carry. When cnt+1 == effective length, go to HOLD. With no accept, hold all state. There is no timeout.
  - HOLD. acc_valid=1; acc_out and overflow are stable. On acc_ready, go to IDLE and drop acc_valid the next cycle. No product is accepted in HOLD, including the cycle in which acc_ready is high.
- Effective length = len, or 2^CNT_W when len == 0. The counter is CNT_W+1 bits wide so that 2^CNT_W does not wrap.
- Latency: acc_valid rises on the cycle after the last product of the block is accepted.
- Minimum block period: len accept cycles plus one HOLD cycle.
- Wrap mode (SAT_EN undefined): acc wraps modulo 2^ACC_W. overflow still reports the carry.
- Changes to block_len mid-block are ignored until the next IDLE accept.
- clear: when asserted, go to IDLE on the next edge. It clears acc_valid, overflow, cnt and acc to 0, and overrides any simultaneous accept or acc_ready.
- Reset mid-block or in HOLD: all state is lost and the outputs return to their reset values asynchronously.
- busy = (state != IDLE).

Optional Feature:
- Macro: MUL_ACC_SAT_EN.
- Defined: on any carry out of ACC_W, acc saturates to all ones and stays there for the rest of the block. overflow is set as in wrap mode.
- Undefined: modulo-2^ACC_W wrap as described in Behaviour.

Test Plan:
- Reset and basic block:
  - Stimulus: rst_n low for 3 cycles, then release; block_len=3; products 6, 10, 0xFFFE0001 accepted back-to-back; acc_ready=1.
  - Required: prod_ready=1 out of reset. acc_valid rises 1 cycle after the third accept with acc_out=0x00FFFE0011 and overflow=0. acc_valid is high for exactly 1 cycle.
- Backpressure:
  - Stimulus: block_len=1; product 0x12345678; acc_ready held low for 5 cycles.
  - Required: acc_valid and acc_out=0x0012345678 stable for all 5 cycles. prod_ready=0 throughout, and a prod_valid pulse during HOLD is not accepted. Returns to IDLE after acc_ready.
- Length 0:
  - Stimulus: block_len=0 with CNT_W=8; 256 products of 0xFFFFFFFF.
  - Required: acc_valid only after accept #256, with acc_out=0xFFFFFFFF00 and overflow=0.
- Overflow, wrap build:
  - Stimulus: ACC_W=33, block_len=3, three products of 0xFFFFFFFF.
  - Required: acc_out=0x0FFFFFFFD and overflow=1.
- Overflow, MUL_ACC_SAT_EN build:
  - Stimulus: same as the wrap test.
  - Required: acc_out=0x1FFFFFFFF and overflow=1.
- Clear and asynchronous reset mid-block:
  - Stimulus, part 1: block_len=4; accept 2 products; pulse clear while prod_valid=1.
  - Required, part 1: that product is not accepted; next cycle busy=0 and acc_out=0; a following 4-product block sums correctly starting from 0.
  - Stimulus, part 2: repeat the 2 accepts, then drop rst_n between clock edges.
  - Required, part 2: outputs reach their reset values before the next edge.
